// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: issues in-order word fetches on a req/gnt/rvalid
// bus, buffers returned words in a small FIFO and hands one instruction (or a
// NOP) per cycle to IF/ID. A jump redirects fetch, empties the FIFO and marks
// every still-outstanding response for discard.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic [PW-1:0] head, tail;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_addr [DEPTH];

  logic          credit_ok, fire, rsp_ok, push, pop;
  logic [CW-1:0] out_next;
  logic [31:0]   target;

  // Issue/pop decisions; a stray rvalid with nothing outstanding is ignored.
  always_comb begin
    target    = jump_addr_i & ~32'h3;
    credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_X;
    ibus_req_o  = rst && (hold_flag_i == 3'd0) && !jump_flag_i && credit_ok;
    ibus_addr_o = fetch_pc;
    fire      = ibus_req_o && ibus_gnt_i;
    rsp_ok    = ibus_rvalid_i && (outstanding != '0);
    push      = rsp_ok && (discard == '0) && !jump_flag_i;
    pop       = rst && (count != '0) && (hold_flag_i == 3'd0) && !jump_flag_i;
    out_next  = outstanding + CW'(fire) - CW'(rsp_ok);
    inst_o       = NOP;
    inst_addr_o  = 32'h0;
    inst_valid_o = 1'b0;
    if (pop) begin
      inst_o       = mem_data[head];
      inst_addr_o  = mem_addr[head];
      inst_valid_o = 1'b1;
    end
  end

  // Control state: PCs, occupancy/credit counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (jump_flag_i) begin
      // Everything in flight now belongs to the old stream and must be dropped.
      fetch_pc    <= target;
      resp_pc     <= target;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= out_next;
      discard     <= out_next;
    end else begin
      outstanding <= out_next;
      if (fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_ok && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        tail    <= tail + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[tail] <= ibus_rdata_i;
      mem_addr[tail] <= resp_pc;
    end
  end

endmodule
